softmax_sum_acc: RTL and testbench

SOFTMAX_SUM_ACC -- requirements
Module: softmax_sum_acc

---
 rtl/softmax_sum_acc_if.sv | 35 +++
 rtl/softmax_sum_acc.sv | 197 +++++++++++++++++++
 tb/tb_softmax_sum_acc.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_sum_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : softmax_sum_acc_if
// Description : Start/stream/result bundle for the softmax denominator adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface softmax_sum_acc_if #(
    parameter int EXP_SIZE      = 8,
    parameter int MANTISSA_SIZE = 7,
    parameter int LEN_W         = 8
);
    localparam int c_DW = 1 + EXP_SIZE + MANTISSA_SIZE;

    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [c_DW-1:0]   in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [c_DW-1:0]   out_sum;
    logic              busy;
    logic              ovf;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, busy, ovf
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/softmax_sum_acc.sv
`default_nettype none
// ============================================================================
// Module      : softmax_sum_acc
// Description : Streams exponentiated softmax terms and accumulates their sum.
// Revision    : 1.0 - initial release
// ============================================================================
module softmax_sum_acc #(
    parameter int EXP_SIZE      = 8,
    parameter int MANTISSA_SIZE = 7,
    parameter int LEN_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    softmax_sum_acc_if.slave bus
);
    localparam int c_DW = 1 + EXP_SIZE + MANTISSA_SIZE;
    localparam int c_W  = MANTISSA_SIZE + 4;
    localparam int c_XW = EXP_SIZE + 2;

    localparam logic [EXP_SIZE-1:0] c_EMAX     = '1;
    localparam logic [EXP_SIZE-1:0] c_EWIN     = EXP_SIZE'(c_W);
    localparam logic [c_XW-1:0]     c_XONE     = c_XW'(1);
    localparam logic [c_XW-1:0]     c_XMAX     = {2'b00, c_EMAX};
    localparam logic [LEN_W-1:0]    c_LONE     = LEN_W'(1);
    localparam logic                c_MODE_ADD = 1'b1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // Single-cycle adder: hidden bit plus guard/round/sticky, round-to-nearest-even,
    // subnormals flushed to zero, results past the top exponent saturate to infinity.
    function automatic logic [c_DW-1:0] fp_add(
        input logic [c_DW-1:0] a,
        input logic [c_DW-1:0] b,
        input logic            mode
    );
        logic [c_DW-1:0]          bb;
        logic [c_DW-1:0]          big;
        logic [c_DW-1:0]          sml;
        logic [EXP_SIZE-1:0]      e_a;
        logic [EXP_SIZE-1:0]      e_b;
        logic [EXP_SIZE-1:0]      e_diff;
        logic [c_W-1:0]           m_big;
        logic [c_W-1:0]           m_sml;
        logic [c_W-1:0]           m_shf;
        logic [c_W-1:0]           m_norm;
        logic [c_W:0]             m_sum;
        logic [c_XW-1:0]          e_res;
        logic [c_XW-1:0]          lz;
        logic [MANTISSA_SIZE+1:0] m_rnd;
        logic                     sticky;
        logic                     rnd_up;
        logic                     found;

        bb  = {b[c_DW-1] ^ ~mode, b[c_DW-2:0]};
        e_a = a[c_DW-2 -: EXP_SIZE];
        e_b = bb[c_DW-2 -: EXP_SIZE];

        if (e_a == c_EMAX) return a;
        if (e_b == c_EMAX) return bb;
        if (e_a == '0)     return (e_b == '0) ? '0 : bb;
        if (e_b == '0)     return a;

        if (bb[c_DW-2:0] > a[c_DW-2:0]) begin
            big = bb;
            sml = a;
        end else begin
            big = a;
            sml = bb;
        end

        m_big  = {1'b1, big[MANTISSA_SIZE-1:0], 3'b000};
        m_sml  = {1'b1, sml[MANTISSA_SIZE-1:0], 3'b000};
        e_diff = big[c_DW-2 -: EXP_SIZE] - sml[c_DW-2 -: EXP_SIZE];

        if (e_diff >= c_EWIN) begin
            m_shf  = '0;
            sticky = 1'b1;
        end else begin
            m_shf  = m_sml >> e_diff;
            sticky = |(m_sml & ~({c_W{1'b1}} << e_diff));
        end
        m_shf[0] = m_shf[0] | sticky;

        e_res = {2'b00, big[c_DW-2 -: EXP_SIZE]};
        lz    = '0;
        found = 1'b0;

        if (big[c_DW-1] == sml[c_DW-1]) begin
            m_sum = {1'b0, m_big} + {1'b0, m_shf};
            if (m_sum[c_W]) begin
                m_norm = m_sum[c_W:1] | {{(c_W-1){1'b0}}, m_sum[0]};
                e_res  = e_res + c_XONE;
            end else begin
                m_norm = m_sum[c_W-1:0];
            end
        end else begin
            m_sum  = {1'b0, m_big} - {1'b0, m_shf};
            m_norm = m_sum[c_W-1:0];
            if (m_norm == '0) return '0;
            for (int i = c_W - 1; i >= 0; i--) begin
                if (!found) begin
                    if (m_norm[i]) found = 1'b1;
                    else           lz    = lz + c_XONE;
                end
            end
            if (e_res <= lz) return '0;
            m_norm = m_norm << lz;
            e_res  = e_res - lz;
        end

        rnd_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
        m_rnd  = {1'b0, m_norm[c_W-1:3]} + {{(MANTISSA_SIZE+1){1'b0}}, rnd_up};
        if (m_rnd[MANTISSA_SIZE+1]) begin
            e_res = e_res + c_XONE;
            m_rnd = m_rnd >> 1;
        end

        if (e_res >= c_XMAX) return {big[c_DW-1], c_EMAX, {MANTISSA_SIZE{1'b0}}};
        return {big[c_DW-1], e_res[EXP_SIZE-1:0], m_rnd[MANTISSA_SIZE-1:0]};
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [c_DW-1:0]  r_acc;
    logic [c_DW-1:0]  w_acc_nxt;
    logic             r_ovf;
    logic             w_accept;
    logic             w_last;

    assign w_accept  = bus.in_valid && (r_state == c_ACCUM);
    assign w_last    = (r_cnt == r_len - c_LONE);
    // First element of a vector seeds the accumulator without going through the adder.
    assign w_acc_nxt = (r_cnt == '0) ? bus.in_data : fp_add(r_acc, bus.in_data, c_MODE_ADD);

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) w_state_nxt = (bus.len == '0) ? c_DONE : c_ACCUM;
            end
            c_ACCUM: begin
                if (w_accept && w_last) w_state_nxt = c_DONE;
            end
            c_DONE: begin
                if (bus.out_ready) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == c_ACCUM);
        bus.out_valid = (r_state == c_DONE);
        bus.busy      = (r_state != c_IDLE);
    end

    assign bus.out_sum = r_acc;
    assign bus.ovf     = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_len <= bus.len;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                        if (bus.len == '0) r_acc <= '0;
                    end
                end
                c_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + c_LONE;
                        if (w_acc_nxt[c_DW-2 -: EXP_SIZE] == c_EMAX) r_ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_softmax_sum_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_softmax_sum_acc
// Description : Vector table plus corner sequences against a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_sum_acc;
    logic clk;
    logic rst;

    softmax_sum_acc_if #(.EXP_SIZE(8), .MANTISSA_SIZE(7), .LEN_W(8)) bus ();

    softmax_sum_acc #(.EXP_SIZE(8), .MANTISSA_SIZE(7), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [7:0]       len;
        logic [3:0][15:0] el;
        logic [7:0]       gap;
        logic [15:0]      sum;
        logic             ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    int   total;
    int   bad;
    exp_t sb_q[$];
    vec_t tbl[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] len, input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3, input logic [7:0] gap,
                                input logic [15:0] sum, input logic ovf);
        vec_t v;
        v.len = len;
        v.el  = {e0, e1, e2, e3};
        v.gap = gap;
        v.sum = sum;
        v.ovf = ovf;
        return v;
    endfunction

    task automatic push_exp(input logic [15:0] sum, input logic ovf);
        exp_t e;
        e.sum = sum;
        e.ovf = ovf;
        sb_q.push_back(e);
    endtask

    // Waits for a result, compares it against the oldest expectation, completes the handshake.
    task automatic drain(input logic with_start);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.out_valid && n < 32) begin
            tick();
            n++;
        end
        if (!bus.out_valid) begin
            total++;
            bad++;
            $display("FAIL out_valid wait: got 0 want 1");
        end else if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected output: got 0x%0h want none", bus.out_sum);
        end else begin
            e = sb_q.pop_front();
            chk("out_sum", 32'(bus.out_sum), 32'(e.sum));
            chk("ovf", 32'(bus.ovf), 32'(e.ovf));
            bus.out_ready = 1'b1;
            bus.start     = with_start;
            bus.len       = 8'd3;
            tick();
            bus.out_ready = 1'b0;
            bus.start     = 1'b0;
            chk("busy after handshake", 32'(bus.busy), 32'd0);
            chk("out_valid after handshake", 32'(bus.out_valid), 32'd0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        push_exp(v.sum, v.ovf);
        bus.start = 1'b1;
        bus.len   = v.len;
        tick();
        bus.start = 1'b0;
        chk("busy after start", 32'(bus.busy), 32'd1);
        chk("in_ready after start", 32'(v.len != 8'd0), 32'(bus.in_ready));
        for (int i = 0; i < int'(v.len); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = v.el[3-i];
            tick();
            if (i < int'(v.len) - 1 && v.gap != 8'd0) begin
                bus.in_valid = 1'b0;
                for (int g = 0; g < int'(v.gap); g++) begin
                    tick();
                    chk("count in gap", 32'(dut.r_cnt), 32'(i + 1));
                    chk("in_ready in gap", 32'(bus.in_ready), 32'd1);
                end
            end
        end
        bus.in_valid = 1'b0;
        chk("out_valid after last", 32'(bus.out_valid), 32'd1);
        chk("in_ready in done", 32'(bus.in_ready), 32'd0);
        drain(1'b0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset ovf", 32'(bus.ovf), 32'd0);
        chk("reset out_sum", 32'(bus.out_sum), 32'd0);

        tbl[0] = mk(8'd4, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 8'd0, 16'h4080, 1'b0);
        tbl[1] = mk(8'd1, 16'h4040, 16'h0000, 16'h0000, 16'h0000, 8'd0, 16'h4040, 1'b0);
        tbl[2] = mk(8'd3, 16'h3F00, 16'h3F00, 16'h4000, 16'h0000, 8'd2, 16'h4040, 1'b0);
        tbl[3] = mk(8'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd0, 16'h0000, 1'b0);
        tbl[4] = mk(8'd2, 16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 8'd0, 16'h7F80, 1'b1);
        tbl[5] = mk(8'd2, 16'h3F80, 16'hBF80, 16'h0000, 16'h0000, 8'd0, 16'h0000, 1'b0);
        tbl[6] = mk(8'd2, 16'h4000, 16'hBF80, 16'h0000, 16'h0000, 8'd0, 16'h3F80, 1'b0);
        tbl[7] = mk(8'd3, 16'h4000, 16'h3F80, 16'h3F00, 16'h0000, 8'd1, 16'h4060, 1'b0);

        for (int t = 0; t < 8; t++) run_vec(tbl[t]);

        // Result held under back-pressure; start during DONE and during handshake is dropped.
        push_exp(16'h4000, 1'b0);
        bus.start = 1'b1;
        bus.len   = 8'd2;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h3F80;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("hold out_valid first", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            bus.start = (k == 1);
            bus.len   = 8'd4;
            tick();
            bus.start = 1'b0;
            chk("hold out_sum", 32'(bus.out_sum), 32'h4000);
            chk("hold out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold in_ready", 32'(bus.in_ready), 32'd0);
        end
        drain(1'b1);
        tick();
        chk("start at handshake ignored", 32'(bus.busy), 32'd0);

        // Reset in the middle of a vector, with start and data also presented that cycle.
        bus.start = 1'b1;
        bus.len   = 8'd4;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h3F80;
        tick();
        tick();
        chk("abort count", 32'(dut.r_cnt), 32'd2);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.len   = 8'd2;
        tick();
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort out_sum", 32'(bus.out_sum), 32'd0);
        tick();
        chk("abort still idle", 32'(bus.busy), 32'd0);
        chk("abort no output", 32'(bus.out_valid), 32'd0);
        run_vec(mk(8'd2, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 8'd0, 16'h4080, 1'b0));

        chk("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
